// File: rtl/bsc_framer.sv
// Bit/sample counter framer: OVERSAMPLE samples per bit, FRAME_BITS bits per frame.
// Define BSC_FRAMER_ABORT_EN to honour the abort input; otherwise abort is ignored.
module bsc_framer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FRAME_BITS = 10,
    localparam int unsigned CNT_W = ($clog2(OVERSAMPLE) > 1) ? $clog2(OVERSAMPLE) : 1,
    localparam int unsigned BIT_W = ($clog2(FRAME_BITS) > 1) ? $clog2(FRAME_BITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             abort,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             sample_stb,
    output logic             bit_done,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  sample_q, sample_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              abort_hit;

`ifdef BSC_FRAMER_ABORT_EN
    assign abort_hit = abort;
`else
    // Port stays for a uniform interface but has no effect in this build.
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    assign busy       = (state_q == StRun);
    assign sample_cnt = sample_q;
    assign bit_cnt    = bit_q;
    assign sample_stb = busy && (sample_q == CNT_W'(OVERSAMPLE / 2));
    assign bit_done   = busy && (sample_q == CNT_W'(OVERSAMPLE - 1));
    assign frame_done = bit_done && (bit_q == BIT_W'(FRAME_BITS - 1));

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        unique case (state_q)
            StIdle: begin
                sample_d = '0;
                bit_d    = '0;
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (frame_done || abort_hit) begin
                    sample_d = '0;
                    bit_d    = '0;
                    // Zero-gap restart only when en is high and no abort overrides it.
                    if (abort_hit || !en) begin
                        state_d = StIdle;
                    end
                end else if (bit_done) begin
                    sample_d = '0;
                    bit_d    = bit_q + BIT_W'(1);
                end else begin
                    sample_d = sample_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                sample_d = '0;
                bit_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sample_q <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
        end
    end

endmodule
